// File: rtl/fifo_mem_ctrl.sv
// Single-clock FIFO controller: sequences a dual-port memory as a circular buffer.
// Produces write/read strobes and addresses, occupancy, status flags and error pulses.
module fifo_mem_ctrl #(
  parameter int ADDRSIZE  = 5,
  parameter int AFULL_TH  = 28,
  parameter int AEMPTY_TH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                push,
  input  logic                pop,
  output logic                mem_write,
  output logic [ADDRSIZE-1:0] mem_wadrs,
  output logic                mem_read,
  output logic [ADDRSIZE-1:0] mem_radrs,
  output logic                rvalid,
  output logic                full,
  output logic                empty,
  output logic                almost_full,
  output logic                almost_empty,
  output logic [ADDRSIZE:0]   count,
  output logic                overflow,
  output logic                underflow
);

  localparam int DEPTH = 1 << ADDRSIZE;
  localparam logic [ADDRSIZE:0] C_AFULL  = (ADDRSIZE+1)'(AFULL_TH);
  localparam logic [ADDRSIZE:0] C_AEMPTY = (ADDRSIZE+1)'(AEMPTY_TH);

  generate
    if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull
      $error("fifo_mem_ctrl: AFULL_TH must be in 1..DEPTH");
    end
    if (AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1) begin : g_bad_aempty
      $error("fifo_mem_ctrl: AEMPTY_TH must be in 0..DEPTH-1");
    end
  endgenerate

  logic [ADDRSIZE:0] r_wptr;
  logic [ADDRSIZE:0] r_rptr;
  logic              r_rvalid;
  logic              r_overflow;
  logic              r_underflow;

  logic              w_full;
  logic              w_empty;
  logic              w_push_ok;
  logic              w_pop_ok;
  logic [ADDRSIZE:0] w_count;

  // Extra wrap bit distinguishes full (same address, different lap) from empty.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[ADDRSIZE-1:0] == r_rptr[ADDRSIZE-1:0]) &&
                   (r_wptr[ADDRSIZE] != r_rptr[ADDRSIZE]);
  assign w_count = r_wptr - r_rptr;

  // A push into a full FIFO is fine when a pop frees the slot on the same edge.
  assign w_pop_ok  = pop  & ~w_empty & ~clear;
  assign w_push_ok = push & (~w_full | w_pop_ok) & ~clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_rvalid    <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (clear) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_rvalid    <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
      r_rvalid    <= w_pop_ok;
      r_overflow  <= push & ~w_push_ok;
      r_underflow <= pop & ~w_pop_ok;
    end
  end

  assign mem_write    = w_push_ok;
  assign mem_read     = w_pop_ok;
  assign mem_wadrs    = r_wptr[ADDRSIZE-1:0];
  assign mem_radrs    = r_rptr[ADDRSIZE-1:0];
  assign rvalid       = r_rvalid;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;
  assign full         = w_full;
  assign empty        = w_empty;
  assign count        = w_count;
  assign almost_full  = (w_count >= C_AFULL);
  assign almost_empty = (w_count <= C_AEMPTY);

endmodule

// File: doc/fifo_mem_ctrl.md
Name: fifo_mem_ctrl

Overview:
Single-clock FIFO controller that sequences the team's dual-port memory as a circular buffer. It converts push/pop requests into memory write and read strobes plus addresses. It keeps the pointers and occupancy, and flags full, empty, almost-full, almost-empty and error conditions. Data does not pass through this block: the requester drives wdata to the memory directly, and rdata is qualified by rvalid.

Parameters:
ADDRSIZE, 5, address bits; FIFO depth DEPTH = 2**ADDRSIZE (32).
AFULL_TH, 28, almost_full asserts when count >= AFULL_TH.
AEMPTY_TH, 4, almost_empty asserts when count <= AEMPTY_TH.

Ports:
clk  input  1  single clock, used for both memory ports at integration (wclk = rclk = clk).
rst_n  input  1  asynchronous active-low reset.
clear  input  1  synchronous flush; empties the FIFO.
push  input  1  write request; data is on memory wdata in the same cycle.
pop  input  1  read request.
mem_write  output  1  memory write enable (combinational).
mem_wadrs  output  ADDRSIZE  memory write address; zero-extended to the memory address width at integration.
mem_read  output  1  memory read enable (combinational).
mem_radrs  output  ADDRSIZE  memory read address; zero-extended at integration.
rvalid  output  1  memory rdata is valid this cycle.
full  output  1  count == DEPTH.
empty  output  1  count == 0.
almost_full  output  1  count >= AFULL_TH.
almost_empty  output  1  count <= AEMPTY_TH.
count  output  ADDRSIZE+1  current occupancy, 0..DEPTH.
overflow  output  1  one-cycle pulse: push rejected.
underflow  output  1  one-cycle pulse: pop rejected.

Behaviour:
- Pointers: wptr and rptr, each ADDRSIZE+1 bits (MSB is the wrap bit). mem_wadrs = wptr[ADDRSIZE-1:0]; mem_radrs = rptr[ADDRSIZE-1:0].
- Wrap-around: pointers increment modulo 2**(ADDRSIZE+1).
- Flags: full when the addresses are equal and the wrap bits differ; empty when the pointers are equal. count = wptr - rptr. All flags are combinational from the registered pointers.
- Accept rules:
  - push_ok = push & (~full | pop_ok)
  - pop_ok = pop & ~empty
  - mem_write = push_ok; mem_read = pop_ok.
- Simultaneous push and pop:
  - Full: both accepted and count unchanged. The write and read target the same address on the same edge, and the read returns the old (oldest) word.
  - Empty: pop rejected (underflow pulses), push accepted.
- Pointer update on the clk edge: wptr increments on push_ok, rptr increments on pop_ok.
- Error pulses, registered one cycle after the request:
  - overflow <= push & ~push_ok
  - underflow <= pop & ~pop_ok
- rvalid <= pop_ok, which aligns with the memory's 1-cycle registered read latency.
- clear: pointers go to 0 and rvalid to 0 on the next edge; push/pop in the same cycle are ignored (mem_write and mem_read forced to 0) and no error pulses are raised.
- Reset: asynchronous on rst_n low. Pointers are 0, so the outputs are:
  - count = 0, empty = 1, almost_empty = 1, full = 0, almost_full = 0.
  - rvalid = 0, overflow = 0, underflow = 0, mem_write = 0, mem_read = 0.
- Reset mid-operation discards contents with no error pulse. An rvalid pending from the pre-reset pop is dropped.
- Parameter rules:
  - AFULL_TH must be in 1..DEPTH and AEMPTY_TH in 0..DEPTH-1.
  - Out-of-range values are a compile-time error (elaboration assertion).
- No combinational path from rdata; the controller never observes data.

Test Plan:
1. Reset release, then 32 consecutive pushes -> mem_wadrs 0..31, count 32, full=1 after the 32nd, almost_full rises at count 28; a 33rd push gives mem_write=0 and an overflow pulse the next cycle.
2. From full, 32 pops -> mem_radrs 0..31, rvalid one cycle after each pop with rdata equal to the pushed words in order, empty=1 at the end; a further pop gives an underflow pulse and rvalid=0.
3. Simultaneous push+pop while full (count 32) for 5 cycles -> count stays 32, no overflow, data order preserved across the wrap.
4. Simultaneous push+pop while empty -> push accepted, pop rejected with underflow, count = 1, no rvalid.
5. Fill to count 10, assert clear together with push -> count 0, empty=1, mem_write=0 that cycle, no error pulses.
6. Pop accepted, then rst_n driven low asynchronously mid-cycle -> all outputs go to reset values immediately and rvalid never asserts.
